// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters that hold back issue
// of any instruction whose source register still has a write in flight (RAW),
// or whose destination counter is already saturated.
module regfile_scoreboard #(
   parameter int REGNUM       = 16,
   parameter int ADDRESSWIDTH = 4,
   parameter int CNTW         = 2,
   parameter int PC_REG       = 7
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           issue_valid,
   output logic                           issue_ready,
   input  logic                           issue_use1,
   input  logic                           issue_use2,
   input  logic [ADDRESSWIDTH-1:0]        issue_ra1,
   input  logic [ADDRESSWIDTH-1:0]        issue_ra2,
   input  logic                           issue_wr,
   input  logic [ADDRESSWIDTH-1:0]        issue_wa,
   input  logic                           wb_valid,
   input  logic [ADDRESSWIDTH-1:0]        wb_wa,
   output logic [REGNUM-1:0]              busy_mask,
   output logic [ADDRESSWIDTH+CNTW-1:0]   outstanding,
   output logic                           wb_error
);

   localparam int OW = ADDRESSWIDTH + CNTW;
   localparam logic [ADDRESSWIDTH-1:0] PC_IDX  = ADDRESSWIDTH'(PC_REG);
   localparam logic [CNTW-1:0]         CNT_MAX = '1;

   logic [CNTW-1:0]   cnt     [REGNUM];
   logic [CNTW-1:0]   cnt_nxt [REGNUM];
   logic [REGNUM-1:0] busy_nxt;
   logic [OW-1:0]     outstanding_nxt;

   logic [CNTW-1:0] c_ra1, c_ra2, c_wa, c_wb;
   logic raw1, raw2, full;
   logic trk_wa, trk_wb;
   logic inc, dec, err;

   // Look up the current (pre-edge) counters and derive hazards; the pc alias is never tracked
   always_comb begin
      c_ra1 = '0;
      c_ra2 = '0;
      c_wa  = '0;
      c_wb  = '0;
      if (int'(issue_ra1) < REGNUM) c_ra1 = cnt[issue_ra1];
      if (int'(issue_ra2) < REGNUM) c_ra2 = cnt[issue_ra2];
      if (int'(issue_wa)  < REGNUM) c_wa  = cnt[issue_wa];
      if (int'(wb_wa)     < REGNUM) c_wb  = cnt[wb_wa];

      raw1 = issue_use1 && (issue_ra1 != PC_IDX) && (c_ra1 != '0);
      raw2 = issue_use2 && (issue_ra2 != PC_IDX) && (c_ra2 != '0);
      full = issue_wr   && (issue_wa  != PC_IDX) && (c_wa == CNT_MAX);
      issue_ready = !(raw1 || raw2 || full);

      trk_wa = (issue_wa != PC_IDX) && (int'(issue_wa) < REGNUM);
      trk_wb = (wb_wa    != PC_IDX) && (int'(wb_wa)    < REGNUM);
      inc = issue_valid && issue_ready && issue_wr && trk_wa;
      dec = wb_valid && trk_wb && (c_wb != '0);
      err = wb_valid && trk_wb && (c_wb == '0);
   end

   // Next-state counters: an increment and decrement on the same register cancel out
   always_comb begin
      cnt_nxt = cnt;
      for (int i = 0; i < REGNUM; i++) begin
         if (inc && (int'(issue_wa) == i) && !(dec && (int'(wb_wa) == i)))
            cnt_nxt[i] = cnt[i] + CNTW'(1);
         else if (dec && (int'(wb_wa) == i) && !(inc && (int'(issue_wa) == i)))
            cnt_nxt[i] = cnt[i] - CNTW'(1);
         busy_nxt[i] = (cnt_nxt[i] != '0);
      end
      case ({inc, dec})
         2'b10:   outstanding_nxt = outstanding + OW'(1);
         2'b01:   outstanding_nxt = outstanding - OW'(1);
         default: outstanding_nxt = outstanding;
      endcase
   end

   // State registers; reset clears everything immediately, even mid-operation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REGNUM; i++) cnt[i] <= '0;
         busy_mask   <= '0;
         outstanding <= '0;
         wb_error    <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         busy_mask   <= busy_nxt;
         outstanding <= outstanding_nxt;
         if (err) wb_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors with hand-computed expectations.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_ready, issue_use1, issue_use2, issue_wr;
   logic [3:0]  issue_ra1, issue_ra2, issue_wa;
   logic        wb_valid;
   logic [3:0]  wb_wa;
   logic [15:0] busy_mask;
   logic [5:0]  outstanding;
   logic        wb_error;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_use1  (issue_use1),
      .issue_use2  (issue_use2),
      .issue_ra1   (issue_ra1),
      .issue_ra2   (issue_ra2),
      .issue_wr    (issue_wr),
      .issue_wa    (issue_wa),
      .wb_valid    (wb_valid),
      .wb_wa       (wb_wa),
      .busy_mask   (busy_mask),
      .outstanding (outstanding),
      .wb_error    (wb_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_ready(input string tag, input logic exp);
      chk(tag, 32'(issue_ready), 32'(exp));
   endtask

   task automatic chk_state(input string tag, input logic [15:0] bm, input logic [5:0] o, input logic e);
      chk({tag, ".busy"}, 32'(busy_mask), 32'(bm));
      chk({tag, ".out"},  32'(outstanding), 32'(o));
      chk({tag, ".err"},  32'(wb_error), 32'(e));
   endtask

   // Drive one cycle's worth of inputs (applied 1 time unit after a rising edge)
   task automatic drive(input logic v, input logic u1, input logic [3:0] ra1,
                        input logic u2, input logic [3:0] ra2,
                        input logic wr, input logic [3:0] wa,
                        input logic wbv, input logic [3:0] wbwa);
      issue_valid = v;  issue_use1 = u1; issue_ra1 = ra1;
      issue_use2  = u2; issue_ra2  = ra2;
      issue_wr    = wr; issue_wa   = wa;
      wb_valid    = wbv; wb_wa     = wbwa;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      repeat (2) tick();
      chk_state("rst0", 16'h0000, 6'd0, 1'b0);
      chk_ready("rst0.ready", 1'b1);
      reset = 1'b0;

      // Reset mid-operation: two writes to r3 in flight, then asynchronous reset
      drive(1, 0, 0, 0, 0, 1, 3, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 1, 3, 0, 0); tick();
      idle();
      chk_state("r3x2", 16'h0008, 6'd2, 1'b0);
      drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
      chk_ready("r3.raw", 1'b0);
      #2 reset = 1'b1;
      #1;
      chk_state("midrst", 16'h0000, 6'd0, 1'b0);
      chk_ready("midrst.ready", 1'b1);
      tick();
      reset = 1'b0;
      idle();

      // RAW stall on r2 with no same-cycle bypass
      drive(1, 0, 0, 0, 0, 1, 2, 0, 0);
      chk_ready("raw.wr2", 1'b1);
      tick();
      drive(1, 1, 2, 0, 0, 0, 0, 1, 2);
      chk_ready("raw.stall", 1'b0);
      chk("raw.busy2", 32'(busy_mask), 32'h0004);
      tick();
      drive(1, 1, 2, 0, 0, 0, 0, 0, 0);
      chk_ready("raw.release", 1'b1);
      chk_state("raw.after", 16'h0000, 6'd0, 1'b0);
      tick();

      // RAW on source 2 (r1)
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();
      drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
      chk_ready("raw2.stall", 1'b0);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk_ready("raw1.r1", 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
      idle();
      chk_state("raw2.after", 16'h0000, 6'd0, 1'b0);

      // Saturation on r5
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
         chk_ready("sat.acc", 1'b1);
         tick();
      end
      idle();
      chk_state("sat.3", 16'h0020, 6'd3, 1'b0);
      drive(1, 0, 0, 0, 0, 1, 5, 1, 5);
      chk_ready("sat.full", 1'b0);
      tick();
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
      chk_state("sat.2", 16'h0020, 6'd2, 1'b0);
      chk_ready("sat.retry", 1'b1);
      tick();
      idle();
      chk("sat.out3", 32'(outstanding), 32'd3);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 5); tick();
      end
      idle();
      chk_state("sat.drain", 16'h0000, 6'd0, 1'b0);

      // Simultaneous increment and decrement on r4
      drive(1, 0, 0, 0, 0, 1, 4, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 1, 4, 1, 4);
      chk_ready("incdec.ready", 1'b1);
      tick();
      idle();
      chk_state("incdec", 16'h0010, 6'd1, 1'b0);

      // Different registers in the same edge: issue r6 while r4 retires
      drive(1, 0, 0, 0, 0, 1, 6, 1, 4); tick();
      idle();
      chk_state("diff", 16'h0040, 6'd1, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 6); tick();
      idle();

      // PC alias is never tracked
      drive(1, 1, 7, 1, 7, 1, 7, 0, 0);
      chk_ready("pc.ready", 1'b1);
      tick();
      drive(1, 1, 7, 1, 7, 1, 7, 1, 7);
      chk_state("pc.issue", 16'h0000, 6'd0, 1'b0);
      chk_ready("pc.ready2", 1'b1);
      tick();
      idle();
      chk_state("pc.wb", 16'h0000, 6'd0, 1'b0);

      // Nothing used: always ready even with everything busy-looking
      drive(1, 0, 0, 0, 0, 1, 8, 0, 0); tick();
      drive(1, 0, 8, 0, 8, 0, 8, 0, 0);
      chk_ready("none.ready", 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 8); tick();
      idle();

      // Spurious writeback to r9 sets a sticky error
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9); tick();
      idle();
      chk_state("spur", 16'h0000, 6'd0, 1'b1);
      drive(1, 0, 0, 0, 0, 1, 6, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 6); tick();
      idle();
      chk_state("spur.sticky", 16'h0000, 6'd0, 1'b1);

      // Reset clears the sticky error
      reset = 1'b1;
      #1;
      chk_state("rst.end", 16'h0000, 6'd0, 1'b0);
      tick();
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks in-flight writes to the register file and gates instruction issue so no instruction reads a register whose pending write has not yet landed (RAW).
- Sits between decode/issue and the register file.
- Issue side declares source and destination registers. Writeback side reports each completed write on the register file write port (we3/wa3).
- Register index PC_REG is never tracked: the register file returns the pc on reads of that index.

Parameters:
- REGNUM, 16, number of architectural registers
- ADDRESSWIDTH, 4, register index width
- CNTW, 2, width of per-register pending-write counter; max outstanding writes per register = 2^CNTW-1
- PC_REG, 7, register index aliased to pc; excluded from tracking

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  1  decode presents an instruction this cycle
- issue_ready  output  1  scoreboard accepts the instruction this cycle (combinational from registered state)
- issue_use1  input  1  instruction reads issue_ra1
- issue_use2  input  1  instruction reads issue_ra2
- issue_ra1  input  ADDRESSWIDTH  source register 1
- issue_ra2  input  ADDRESSWIDTH  source register 2
- issue_wr  input  1  instruction will write issue_wa
- issue_wa  input  ADDRESSWIDTH  destination register
- wb_valid  input  1  one register write completes this cycle (mirrors we3)
- wb_wa  input  ADDRESSWIDTH  register written (mirrors wa3)
- busy_mask  output  REGNUM  bit i = 1 when counter i is nonzero (registered)
- outstanding  output  ADDRESSWIDTH+CNTW  total pending writes across all registers (registered)
- wb_error  output  1  sticky flag: writeback to a register with zero pending writes

Behaviour:
- State:
  - cnt[i], CNTW bits, for i = 0..REGNUM-1.
  - outstanding total register.
  - wb_error flag.
- Reset (async, immediate, mid-operation included): all cnt = 0, busy_mask = 0, outstanding = 0, wb_error = 0. issue_ready therefore follows only inputs while reset is held.
- Hazard conditions (evaluated on current registered counters, not next-state):
  - raw1 = issue_use1 && issue_ra1 != PC_REG && cnt[issue_ra1] != 0
  - raw2 = same form for ra2
  - full = issue_wr && issue_wa != PC_REG && cnt[issue_wa] == max
- issue_ready = !(raw1 || raw2 || full). It does not depend on issue_valid.
- No same-cycle writeback bypass: a wb to a register does not clear a RAW stall on that register until the next cycle. This matches the register file, whose write lands at the clock edge.
- Accept = issue_valid && issue_ready. On accept with issue_wr and issue_wa != PC_REG: increment cnt[issue_wa].
- Writeback with wb_valid and wb_wa != PC_REG:
  - If cnt[wb_wa] != 0: decrement it.
  - If cnt[wb_wa] == 0: counter stays 0 and wb_error is set (sticky until reset).
- Simultaneous accept-increment and writeback-decrement on the same register: net count unchanged. The full check still uses the pre-edge count, so at max the issue is stalled even if a wb to that register occurs the same cycle.
- Simultaneous events on different registers: both apply independently in the same edge.
- Writes to PC_REG on either side are ignored; accept is still granted.
- outstanding is updated by +1 on tracked increment, -1 on valid decrement, and net 0 when both occur. It always equals the sum of cnt.
- Latency: accepted issue is reflected in busy_mask and outstanding one cycle later. Same for wb.
- An instruction with issue_use1/issue_use2/issue_wr all 0 is always ready.

Test Plan:
- Reset mid-operation: set cnt[3] = 2, assert reset between edges -> busy_mask = 0, outstanding = 0, wb_error = 0 immediately. An issue reading r3 is ready.
- RAW stall:
  - Issue wr r2 (accepted). Next cycle, issue reading r2 -> issue_ready = 0.
  - wb_valid wb_wa = 2 in that same cycle -> issue_ready still 0 that cycle, becomes 1 the following cycle.
  - busy_mask[2]: 1 -> 0.
- Counter saturation (CNTW = 2):
  - Accept three writes to r5 -> cnt = 3, outstanding = 3.
  - Fourth write to r5 -> issue_ready = 0, even with a concurrent wb to r5.
  - After that wb, cnt = 2 and the fourth write is accepted next cycle.
- Simultaneous inc/dec: cnt[4] = 1; same cycle accept write r4 and wb r4 -> cnt[4] stays 1, outstanding unchanged, busy_mask[4] = 1.
- PC_REG: issue reading r7 and writing r7 with no history -> ready; busy_mask[7] stays 0. wb to r7 -> no wb_error.
- Spurious writeback: wb_valid wb_wa = 9 with cnt[9] = 0 -> wb_error = 1 next cycle and remains 1 through later traffic. cnt[9] stays 0, outstanding unchanged.
